edge_event_array: RTL
=====================

# edge_event_array

Parametrised multi-channel edge-event unit. Each of CH asynchronous level inputs is synchronised into the `clk` domain through a configurable-depth flop chain. Each synchronised input then passes through a per-channel glitch filter and a per-channel edge detector (rise/fall/any/off). Each channel produces a one-cycle event pulse, a sticky write-1-to-clear status bit, and a saturating event counter. A single aggregated interrupt line is also provided. The block sits between raw detector/trigger lines and the control-register/interrupt logic of the readout FPGA.

## Interface
Parameters:
- `CH`, 8, number of channels (1..32)
- `SYNC_STAGES`, 2, synchroniser depth per channel (>=2)
- `FILT_W`, 4, width of glitch-filter length and per-channel filter counter
- `CNT_W`, 8, width of each per-channel event counter

Ports:
- `clk`  in  1  single block clock
- `rst`  in  1  reset; synchronous, active-high
- `sig_in`  in  CH  asynchronous level inputs, bit i = channel i
- `mode`  in  2*CH  per-channel mode, bits [2i+1:2i]; 00 off, 01 rising, 10 falling, 11 any edge
- `filt_len`  in  FILT_W  required stable cycles before filtered level changes; 0 treated as 1
- `clr`  in  CH  write-1-to-clear for `sticky`, one-cycle pulses
- `cnt_clr`  in  1  zero all event counters
- `edge_pulse`  out  CH  one-cycle registered event pulse per channel
- `sticky`  out  CH  latched event status
- `evt_cnt`  out  CH*CNT_W  per-channel saturating event count, channel i at [CNT_W*i +: CNT_W]
- `irq`  out  1  registered OR of `sticky`

## Operation
- Synchroniser: chain `s[0..SYNC_STAGES-1]` per channel; `s[0]` samples `sig_in`; `sync` = last stage.
- Filter state per channel: `filt_lvl` (1 bit) and `fcnt` (FILT_W bits).
  - `sync == filt_lvl` → `fcnt` <= 0.
  - Otherwise, with k = max(filt_len,1): if `fcnt+1 >= k`, then `filt_lvl` <= `sync` and `fcnt` <= 0; else `fcnt` <= `fcnt+1`.
  - A pulse shorter than k cycles at `sync` never changes `filt_lvl`.
- Edge detection is evaluated on the `filt_lvl` transition at the same clock edge the toggle occurs.
  - rise = toggle 0→1; fall = toggle 1→0.
  - `edge_pulse[i]` <= (rise & mode bit0) | (fall & mode bit1).
- Filter and synchroniser always run regardless of `mode`. `mode`=00 suppresses only pulse, sticky and count.
- `sticky[i]` is set on the same edge `edge_pulse[i]` is registered high. Otherwise it clears when `clr[i]`=1. Set has priority over clear in the same cycle.
- `evt_cnt[i]` increments on the same edge as the pulse and saturates at 2^CNT_W-1, with no wrap.
  - `cnt_clr` zeroes all counters.
  - `cnt_clr` together with an event on channel i loads `evt_cnt[i]` = 1.
- `irq` <= |`sticky` (next-state values), registered, so `irq` rises on the same edge as `sticky`.
- `mode` and `filt_len` changes take effect on the next clock edge.
  - An in-progress `fcnt` is compared against the new k.
  - If `fcnt+1 >= new k` and `sync` still differs, the toggle happens at that edge.

## Timing
- Reset values: all synchroniser stages, `filt_lvl`, `fcnt`, `edge_pulse`, `sticky`, `evt_cnt` and `irq` are 0.
- `rst` overrides every other input, including mid-filter-count and mid-pulse. The next cycle after deassertion starts from the reset state.
- An input held high across reset release is detected as a rising edge after the normal latency.
- Latency: `sig_in` stable before edge 1 → `sync` valid after edge SYNC_STAGES → `edge_pulse`, `sticky`, count and `irq` update after edge SYNC_STAGES+k.
  - Default parameters with filt_len ≤ 1: 3 cycles.
- `edge_pulse` is exactly one cycle wide per filtered transition.
- The minimum filtered-transition spacing is k cycles, so back-to-back pulses on one channel are possible when k=1.
- Channels are fully independent. Simultaneous events on all channels each set their own sticky bit and counter in the same cycle.

## Test plan
- Reset and single rise: SYNC_STAGES=2, filt_len=0, mode ch0=01, `sig_in[0]` 0→1 before edge 1 → `edge_pulse[0]` high after edge 3 for one cycle; `sticky[0]`=1 and `irq`=1 after edge 3; `evt_cnt[0]`=1.
- Glitch filter: filt_len=4, mode=11. A 3-cycle high pulse gives no pulse and `evt_cnt`=0. A 4-cycle high pulse gives a rise pulse at edge SYNC_STAGES+4 after onset, then a fall pulse 4 cycles after the input returns low; `evt_cnt`=2.
- Mode masking: mode=10 on a 0→1→0 input gives a pulse only on the fall. Mode=00 gives no pulse, `sticky`=0 and count unchanged, while `filt_lvl` still tracks the input.
- Sticky priority: `clr[0]`=1 in the same cycle an event registers → `sticky[0]` stays 1. `clr[0]` alone on a later cycle → `sticky[0]`=0 next cycle and `irq`=0 when no other sticky bit is set.
- Counter saturation/clear: CNT_W=8, 300 filtered edges → `evt_cnt[0]`=255. `cnt_clr` coincident with an event → 1. `cnt_clr` alone → 0.
- Reset mid-operation: assert `rst` with `fcnt`=2 of filt_len=4 and `sticky`=1 → all outputs 0 next cycle; input held high produces a rise after SYNC_STAGES+4 cycles following release.

Source files
------------

// File: rtl/edge_event_array.sv
// Multi-channel edge-event unit: per-channel synchroniser, glitch filter and
// edge detector feeding event pulses, sticky status, saturating counters and an irq.
module edge_event_array #(
  parameter int unsigned CH          = 8,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FILT_W      = 4,
  parameter int unsigned CNT_W       = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [CH-1:0]         sig_in,
  input  logic [2*CH-1:0]       mode,
  input  logic [FILT_W-1:0]     filt_len,
  input  logic [CH-1:0]         clr,
  input  logic                  cnt_clr,
  output logic [CH-1:0]         edge_pulse,
  output logic [CH-1:0]         sticky,
  output logic [CH*CNT_W-1:0]   evt_cnt,
  output logic                  irq
);

  localparam int unsigned KW = FILT_W + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CH-1:0]             sync_q [SYNC_STAGES];
  logic [CH-1:0]             sync;
  logic [CH-1:0]             filt_lvl;
  logic [CH-1:0]             filt_lvl_nx;
  logic [CH-1:0][FILT_W-1:0] fcnt;
  logic [CH-1:0][FILT_W-1:0] fcnt_nx;
  logic [CH-1:0]             evt;
  logic [CH-1:0]             sticky_nx;
  logic [CH-1:0][CNT_W-1:0]  cnt_q;
  logic [CH-1:0][CNT_W-1:0]  cnt_nx;
  logic [KW-1:0]             k;

  assign sync    = sync_q[SYNC_STAGES-1];
  assign k       = (filt_len == '0) ? KW'(1) : KW'(filt_len);
  assign evt_cnt = cnt_q;

  // Synchroniser chain; stage 0 samples the asynchronous inputs
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
    end else begin
      sync_q[0] <= sig_in;
      for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
    end
  end

  // Filter, edge qualification by mode, sticky and counter next-state
  always_comb begin
    filt_lvl_nx = filt_lvl;
    fcnt_nx     = fcnt;
    evt         = '0;
    sticky_nx   = sticky & ~clr;
    cnt_nx      = cnt_q;
    for (int i = 0; i < CH; i++) begin
      if (sync[i] == filt_lvl[i]) begin
        fcnt_nx[i] = '0;
      end else if ((KW'(fcnt[i]) + KW'(1)) >= k) begin
        filt_lvl_nx[i] = sync[i];
        fcnt_nx[i]     = '0;
        evt[i]         = sync[i] ? mode[2*i] : mode[2*i+1];
      end else begin
        fcnt_nx[i] = fcnt[i] + FILT_W'(1);
      end
      if (evt[i]) sticky_nx[i] = 1'b1;
      // A clear coincident with an event leaves that event counted
      if (cnt_clr) begin
        cnt_nx[i] = CNT_W'(evt[i]);
      end else if (evt[i] && (cnt_q[i] != CNT_MAX)) begin
        cnt_nx[i] = cnt_q[i] + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      filt_lvl   <= '0;
      fcnt       <= '0;
      edge_pulse <= '0;
      sticky     <= '0;
      cnt_q      <= '0;
      irq        <= 1'b0;
    end else begin
      filt_lvl   <= filt_lvl_nx;
      fcnt       <= fcnt_nx;
      edge_pulse <= evt;
      sticky     <= sticky_nx;
      cnt_q      <= cnt_nx;
      irq        <= |sticky_nx;
    end
  end

endmodule
